// File: rtl/mypio_pkg.sv
// mypio shared constants: register offsets,
// CTRL bit positions and edge capture modes.
package mypio_pkg;

  localparam logic [3:0] OFF_SWDATA = 4'd8;
  localparam logic [3:0] OFF_EDGE   = 4'd9;
  localparam logic [3:0] OFF_MASK   = 4'd10;
  localparam logic [3:0] OFF_CTRL   = 4'd11;

  localparam int CTRL_SCAN_EN = 0;
  localparam int CTRL_BLANK   = 1;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/mypio_scan.sv
// Digit scan: slot divider, digit index and
// registered one-cold digit enable decode.
module mypio_scan #(
  parameter  int NDIGIT   = 4,
  parameter  int SCAN_DIV = 50000,
  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              blank,
  output logic [IW-1:0]     sel,
  output logic              dblank,
  output logic [NDIGIT-1:0] ndig
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(NDIGIT - 1);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [NDIGIT-1:0] onecold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt == TC) begin
        cnt <= '0;
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb onecold = ~(NDIGIT'(1) << idx);

  // sel/dblank travel with ndig so nHEX lines up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ndig   <= '1;
      sel    <= '0;
      dblank <= 1'b1;
    end else begin
      ndig   <= blank ? '1 : onecold;
      sel    <= idx;
      dblank <= blank;
    end
  end

endmodule

// File: rtl/mypio_hexscan.sv
// Avalon-MM PIO: switch edge capture with irq and
// a multiplexed 7-segment display scanner.
module mypio_hexscan
  import mypio_pkg::*;
#(
  parameter int NDIGIT    = 4,
  parameter int SWW       = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int EDGE_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        address,
  input  logic              write,
  input  logic              read,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              irq,
  input  logic [SWW-1:0]    SW,
  output logic [6:0]        nHEX,
  output logic [NDIGIT-1:0] nDIG
);

  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

  logic [6:0]     seg [NDIGIT];
  logic [SWW-1:0] s1, s2, s3;
  logic [SWW-1:0] edge_q, mask_q;
  logic [SWW-1:0] rise, fall, det, clr;
  logic [1:0]     ctrl;
  logic [2:0]     arm;
  logic [IW-1:0]  sel;
  logic           dblank;
  logic [7:0]     rmux;

  // arm holds off detection until s3 carries a real sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      arm <= '0;
    end else begin
      s1  <= SW;
      s2  <= s1;
      s3  <= s2;
      arm <= {arm[1:0], 1'b1};
    end
  end

  always_comb begin
    rise = s2 & ~s3;
    fall = ~s2 & s3;
    det  = '0;
    if (arm[2]) begin
      if (EDGE_MODE == EDGE_FALL)
        det = fall;
      else if (EDGE_MODE == EDGE_BOTH)
        det = rise | fall;
      else
        det = rise;
    end
  end

  always_comb begin
    clr = '0;
    if (write && address == OFF_EDGE)
      clr = writedata[SWW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NDIGIT; i++)
        seg[i] <= 7'h7f;
      edge_q <= '0;
      mask_q <= '0;
      ctrl   <= 2'b01;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~clr) | det;
      irq    <= |(edge_q & mask_q);
      if (write) begin
        for (int i = 0; i < NDIGIT; i++)
          if (address == 4'(i))
            seg[i] <= writedata[6:0];
        if (address == OFF_MASK)
          mask_q <= writedata[SWW-1:0];
        if (address == OFF_CTRL)
          ctrl <= writedata[1:0];
      end
    end
  end

  always_comb begin
    rmux = '0;
    for (int i = 0; i < NDIGIT; i++)
      if (address == 4'(i))
        rmux = {1'b0, seg[i]};
    if (address == OFF_SWDATA)
      rmux[SWW-1:0] = s2;
    else if (address == OFF_EDGE)
      rmux[SWW-1:0] = edge_q;
    else if (address == OFF_MASK)
      rmux[SWW-1:0] = mask_q;
    else if (address == OFF_CTRL)
      rmux[1:0] = ctrl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      readdata <= '0;
    else
      readdata <= read ? rmux : 8'h00;
  end

  mypio_scan #(
    .NDIGIT   (NDIGIT),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl[CTRL_SCAN_EN]),
    .blank  (ctrl[CTRL_BLANK]),
    .sel    (sel),
    .dblank (dblank),
    .ndig   (nDIG)
  );

  // segment data read live so SEG writes show next cycle
  always_comb begin
    nHEX = 7'h7f;
    if (!dblank)
      for (int i = 0; i < NDIGIT; i++)
        if (sel == IW'(i))
          nHEX = seg[i];
  end

endmodule

// File: tb/tb_mypio_hexscan.sv
// Bench for mypio_hexscan: 4-digit and 1-digit
// builds checked against a behavioural model.
module tb_mypio_hexscan;

  localparam int SDIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] address = '0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] writedata = '0;
  logic [3:0] SW = '0;

  logic [7:0] readdata, readdata1;
  logic       irq, irq1;
  logic [6:0] nHEX, nHEX1;
  logic [3:0] nDIG;
  logic [0:0] nDIG1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mypio_hexscan #(
    .NDIGIT(4), .SWW(4),
    .SCAN_DIV(SDIV), .EDGE_MODE(0)
  ) dut (
    .clk(clk), .reset(reset),
    .address(address), .write(write),
    .read(read), .writedata(writedata),
    .readdata(readdata), .irq(irq),
    .SW(SW), .nHEX(nHEX), .nDIG(nDIG)
  );

  mypio_hexscan #(
    .NDIGIT(1), .SWW(4),
    .SCAN_DIV(2), .EDGE_MODE(0)
  ) dut1 (
    .clk(clk), .reset(reset),
    .address(address), .write(write),
    .read(read), .writedata(writedata),
    .readdata(readdata1), .irq(irq1),
    .SW(SW), .nHEX(nHEX1), .nDIG(nDIG1)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  logic [6:0] m_seg [8];
  logic [3:0] m_edge, m_mask;
  logic [1:0] m_ctrl;
  logic [3:0] swq [$];
  int         m_k, m_dsel;
  logic       m_dblank, m_irq;
  logic [7:0] m_rd;
  logic [3:0] m_ndig;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_seg[i] = 7'h7f;
      m_edge = '0;
      m_mask = '0;
      m_ctrl = 2'b01;
      swq.delete();
      m_k = 0;
      m_dsel = 0;
      m_dblank = 1'b1;
      m_rd = '0;
      m_irq = 1'b0;
      m_ndig = 4'hf;
    end else begin : mdl
      logic [3:0] det, clr, swd;
      int idx;
      swd = (swq.size() >= 2) ? swq[1] : 4'h0;
      det = (swq.size() >= 3) ? (swq[1] & ~swq[2]) : 4'h0;
      m_rd = '0;
      if (read) begin
        if (address < 4) m_rd = {1'b0, m_seg[address]};
        else if (address == 8) m_rd = {4'h0, swd};
        else if (address == 9) m_rd = {4'h0, m_edge};
        else if (address == 10) m_rd = {4'h0, m_mask};
        else if (address == 11) m_rd = {6'h0, m_ctrl};
      end
      m_irq = |(m_edge & m_mask);
      idx = (m_k / SDIV) % 4;
      m_ndig = m_ctrl[1] ? 4'hf : ~(4'b0001 << idx);
      m_dsel = idx;
      m_dblank = m_ctrl[1];
      if (m_ctrl[0]) m_k++;
      clr = '0;
      if (write) begin
        if (address < 4) m_seg[address] = writedata[6:0];
        else if (address == 9) clr = writedata[3:0];
        else if (address == 10) m_mask = writedata[3:0];
        else if (address == 11) m_ctrl = writedata[1:0];
      end
      m_edge = (m_edge & ~clr) | det;
      swq.push_front(SW);
      if (swq.size() > 3) void'(swq.pop_back());
    end
  end

  always @(negedge clk) begin
    check("readdata", readdata, m_rd);
    check("irq", irq, m_irq);
    check("nhex", nHEX,
          m_dblank ? 7'h7f : m_seg[m_dsel]);
    check("ndig", nDIG, m_ndig);
    check("irq1", irq1, m_irq);
    check("ndig1", nDIG1, m_dblank);
    check("nhex1", nHEX1,
          m_dblank ? 7'h7f : m_seg[0]);
  end

  // ---- stimulus ----
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [7:0] d);
    address = a;
    writedata = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [7:0] e,
                    input string nm);
    address = a;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check(nm, readdata, e);
  endtask

  logic [3:0] dseq [4] = '{4'b1101, 4'b1011,
                           4'b0111, 4'b1110};
  logic [6:0] sv [4] = '{7'h40, 7'h79,
                         7'h24, 7'h30};

  initial begin : stim
    logic [3:0] hold;
    bit ok;
    @(negedge clk);
    check("rst_rd", readdata, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_nhex", nHEX, 7'h7f);
    check("rst_ndig", nDIG, 4'hf);
    check("rst_ndig1", nDIG1, 1'b1);
    #7 reset = 1'b1;
    @(negedge clk);

    rd(0, 8'h7f, "seg0_rst");
    rd(11, 8'h01, "ctrl_rst");
    rd(9, 8'h00, "edge_rst");
    wr(2, 8'h24);
    rd(2, 8'h24, "seg2_rb");
    rd(12, 8'h00, "off12");
    wr(2, 8'ha4);
    rd(2, 8'h24, "seg2_bit7");
    wr(13, 8'hff);
    rd(13, 8'h00, "off13");
    wr(10, 8'hff);
    rd(10, 8'h0f, "mask_w");
    wr(10, 8'h00);

    for (int i = 0; i < 4; i++)
      wr(4'(i), {1'b0, sv[i]});
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (nDIG == 4'b1110) ok = 1;
    end
    check("scan_start", ok, 1'b1);
    check("scan_hex0", nHEX, 7'h40);
    for (int j = 0; j < 4; j++) begin
      repeat (SDIV) tick();
      check("scan_dig", nDIG, dseq[j]);
      check("scan_hex", nHEX, sv[(j + 1) % 4]);
    end
    check("one_ndig", nDIG1, 1'b0);
    check("one_nhex", nHEX1, 7'h40);

    wr(10, 8'h01);
    SW = 4'h1;
    ok = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      tick();
      if (irq) ok = 1;
    end
    check("irq_rise", ok, 1'b1);
    rd(9, 8'h01, "edge_set");
    rd(8, 8'h01, "swdata");
    wr(9, 8'h01);
    tick();
    check("irq_clr", irq, 1'b0);
    rd(9, 8'h00, "edge_clr");
    SW = 4'h0;
    repeat (5) tick();
    rd(9, 8'h00, "fall_ignored");
    SW = 4'h1;
    tick();
    tick();
    wr(9, 8'h01);
    rd(9, 8'h01, "edge_wins");

    wr(11, 8'h03);
    tick();
    check("blank_ndig", nDIG, 4'hf);
    check("blank_nhex", nHEX, 7'h7f);
    rd(11, 8'h03, "ctrl_rb");
    wr(11, 8'h00);
    tick();
    hold = nDIG;
    ok = (hold != 4'hf);
    check("freeze_unblank", ok, 1'b1);
    ok = 1;
    repeat (3 * SDIV + 1) begin
      tick();
      if (nDIG != hold) ok = 0;
    end
    check("freeze_hold", ok, 1'b1);
    wr(11, 8'h01);
    repeat (3) tick();

    address = 4'd11;
    read = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("amid_rd", readdata, 8'h00);
    check("amid_irq", irq, 1'b0);
    check("amid_nhex", nHEX, 7'h7f);
    check("amid_ndig", nDIG, 4'hf);
    read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    wr(10, 8'h01);
    repeat (8) tick();
    check("post_irq", irq, 1'b0);
    rd(9, 8'h00, "post_edge");
    rd(8, 8'h01, "post_sw");
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
